// File: rtl/serial_tx_pkg.sv
// Shared types and constants for the serial message transmitter:
// serializer states, index widths, line idle level and baud counter sizing.
package serial_tx_pkg;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    localparam int   BYTE_IDX_W = 2;
    localparam int   BIT_IDX_W  = 3;
    localparam logic UART_IDLE  = 1'b1;

    // Smallest down-counter width able to hold BAUD_DIV-1, never below one bit.
    function automatic int baudCntWidth(input int baudDiv);
        int w;
        w = 1;
        while ((1 << w) < baudDiv) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/serial_msg_fifo.sv
// Synchronous word FIFO; the depth is a power of two so the read and write
// pointers wrap on their own and the occupancy count is the only full/empty source.
module serial_msg_fifo
    import serial_tx_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             enq_i,
    input  logic [WIDTH-1:0] enqData_i,
    input  logic             deq_i,
    output logic [WIDTH-1:0] deqData_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q;
    logic [AW-1:0]    rdPtr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             doEnq;
    logic             doDeq;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign deqData_o = mem_q[rdPtr_q];

    assign doEnq = enq_i && !full_o;
    assign doDeq = deq_i && !empty_o;

    always_comb begin
        count_d = count_q;
        case ({doEnq, doDeq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doEnq) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (doDeq) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk_i) begin
        if (doEnq) begin
            mem_q[wrPtr_q] <= enqData_i;
        end
    end

endmodule

// File: rtl/serial_msg_tx.sv
// Transmit end of the serial message channel: buffers 32-bit puts and sends
// each word as four little-endian 8N1 bytes on a registered UART TX line.
module serial_msg_tx
    import serial_tx_pkg::*;
#(
    parameter int BAUD_DIV   = 868,
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 1
) (
    input  logic        sys_clk_pin,
    input  logic        sys_rst_pin,
    input  logic [31:0] msg_in_put,
    input  logic        EN_msg_in_put,
    output logic        RDY_msg_in_put,
    output logic        uart_tx_pin,
    output logic        tx_busy
);

    localparam int               CNT_W      = baudCntWidth(BAUD_DIV);
    localparam int               FIFO_CW    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] BIT_RELOAD = CNT_W'(BAUD_DIV - 1);
    localparam logic             LAST_STOP  = (STOP_BITS == 2);

    logic [1:0]            rstSync_q;
    logic                  rstInt_n;

    logic                  fifoEnq;
    logic                  fifoDeq;
    logic                  fifoFull;
    logic                  fifoEmpty;
    logic [31:0]           fifoData;
    logic [FIFO_CW-1:0]    fifoCount;

    tx_state_e             state_q;
    logic [31:0]           shift_q;
    logic [CNT_W-1:0]      baudCnt_q;
    logic [BIT_IDX_W-1:0]  bitIdx_q;
    logic [BYTE_IDX_W-1:0] byteIdx_q;
    logic                  stopIdx_q;
    logic                  txLine_q;

    logic                  bitDone;
    logic                  wordDone;

    // Assertion reaches every flop at once; release is retimed through two flops.
    always_ff @(posedge sys_clk_pin or negedge sys_rst_pin) begin
        if (!sys_rst_pin) begin
            rstSync_q <= 2'b00;
        end else begin
            rstSync_q <= {rstSync_q[0], 1'b1};
        end
    end

    assign rstInt_n = rstSync_q[1];

    assign RDY_msg_in_put = rstInt_n && !fifoFull;
    assign fifoEnq        = EN_msg_in_put && RDY_msg_in_put;

    assign bitDone  = (baudCnt_q == '0);
    assign wordDone = (state_q == TX_STOP) && bitDone && (stopIdx_q == LAST_STOP)
                      && (byteIdx_q == '1);
    assign fifoDeq  = !fifoEmpty && ((state_q == TX_IDLE) || wordDone);

    assign tx_busy     = (state_q != TX_IDLE) || (fifoCount != '0);
    assign uart_tx_pin = txLine_q;

    serial_msg_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (sys_clk_pin),
        .rst_ni    (rstInt_n),
        .enq_i     (fifoEnq),
        .enqData_i (msg_in_put),
        .deq_i     (fifoDeq),
        .deqData_o (fifoData),
        .full_o    (fifoFull),
        .empty_o   (fifoEmpty),
        .count_o   (fifoCount)
    );

    // The line flop follows the state one cycle late, so every bit keeps its
    // full BAUD_DIV width and the pin never sees a combinational glitch.
    always_ff @(posedge sys_clk_pin or negedge rstInt_n) begin
        if (!rstInt_n) begin
            state_q   <= TX_IDLE;
            shift_q   <= '0;
            baudCnt_q <= '0;
            bitIdx_q  <= '0;
            byteIdx_q <= '0;
            stopIdx_q <= 1'b0;
            txLine_q  <= UART_IDLE;
        end else begin
            case (state_q)
                TX_START: txLine_q <= 1'b0;
                TX_DATA:  txLine_q <= shift_q[0];
                default:  txLine_q <= UART_IDLE;
            endcase

            case (state_q)
                TX_IDLE: begin
                    if (fifoDeq) begin
                        shift_q   <= fifoData;
                        byteIdx_q <= '0;
                        baudCnt_q <= BIT_RELOAD;
                        state_q   <= TX_START;
                    end
                end
                TX_START: begin
                    if (bitDone) begin
                        baudCnt_q <= BIT_RELOAD;
                        bitIdx_q  <= '0;
                        state_q   <= TX_DATA;
                    end else begin
                        baudCnt_q <= baudCnt_q - 1'b1;
                    end
                end
                TX_DATA: begin
                    if (bitDone) begin
                        baudCnt_q <= BIT_RELOAD;
                        shift_q   <= {1'b0, shift_q[31:1]};
                        if (bitIdx_q == '1) begin
                            stopIdx_q <= 1'b0;
                            state_q   <= TX_STOP;
                        end else begin
                            bitIdx_q <= bitIdx_q + 1'b1;
                        end
                    end else begin
                        baudCnt_q <= baudCnt_q - 1'b1;
                    end
                end
                TX_STOP: begin
                    if (bitDone) begin
                        baudCnt_q <= BIT_RELOAD;
                        if (stopIdx_q != LAST_STOP) begin
                            stopIdx_q <= 1'b1;
                        end else if (byteIdx_q != '1) begin
                            byteIdx_q <= byteIdx_q + 1'b1;
                            state_q   <= TX_START;
                        end else if (fifoDeq) begin
                            shift_q   <= fifoData;
                            byteIdx_q <= '0;
                            state_q   <= TX_START;
                        end else begin
                            state_q <= TX_IDLE;
                        end
                    end else begin
                        baudCnt_q <= baudCnt_q - 1'b1;
                    end
                end
                default: state_q <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_msg_tx.sv
// Scoreboard bench for serial_msg_tx: accepted puts queue expected words, and an
// independent UART receiver per instance decodes the line and pops/compares them.
module tb_serial_msg_tx;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic [31:0] data0 = '0, data1 = '0, data2 = '0;
    logic        en0 = 1'b0, en1 = 1'b0, en2 = 1'b0;
    logic        rdy0, rdy1, rdy2;
    logic        line0, line1, line2;
    logic        busy0, busy1, busy2;

    int          cycleCnt = 0;
    int          nCompared = 0;
    int          nMismatch = 0;
    int          lastPutCycle = 0;
    int          lastWordGap [3];
    int          wordsSeen [3];
    logic [31:0] expQ0 [$];
    logic [31:0] expQ1 [$];
    logic [31:0] expQ2 [$];

    always #5 clk = ~clk;
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Three configurations share clock and reset: baseline, two stop bits, minimum baud divider.
    serial_msg_tx #(.BAUD_DIV(4), .FIFO_DEPTH(4), .STOP_BITS(1)) dut0 (
        .sys_clk_pin(clk), .sys_rst_pin(rstN), .msg_in_put(data0), .EN_msg_in_put(en0),
        .RDY_msg_in_put(rdy0), .uart_tx_pin(line0), .tx_busy(busy0));
    serial_msg_tx #(.BAUD_DIV(4), .FIFO_DEPTH(4), .STOP_BITS(2)) dut1 (
        .sys_clk_pin(clk), .sys_rst_pin(rstN), .msg_in_put(data1), .EN_msg_in_put(en1),
        .RDY_msg_in_put(rdy1), .uart_tx_pin(line1), .tx_busy(busy1));
    serial_msg_tx #(.BAUD_DIV(2), .FIFO_DEPTH(4), .STOP_BITS(1)) dut2 (
        .sys_clk_pin(clk), .sys_rst_pin(rstN), .msg_in_put(data2), .EN_msg_in_put(en2),
        .RDY_msg_in_put(rdy2), .uart_tx_pin(line2), .tx_busy(busy2));

    function automatic int baudOf(input int k);
        return (k == 2) ? 2 : 4;
    endfunction

    function automatic int stopsOf(input int k);
        return (k == 1) ? 2 : 1;
    endfunction

    function automatic logic lineOf(input int k);
        case (k)
            0:       return line0;
            1:       return line1;
            default: return line2;
        endcase
    endfunction

    function automatic logic rdyOf(input int k);
        case (k)
            0:       return rdy0;
            1:       return rdy1;
            default: return rdy2;
        endcase
    endfunction

    function automatic logic busyOf(input int k);
        case (k)
            0:       return busy0;
            1:       return busy1;
            default: return busy2;
        endcase
    endfunction

    function automatic int qSize(input int k);
        case (k)
            0:       return expQ0.size();
            1:       return expQ1.size();
            default: return expQ2.size();
        endcase
    endfunction

    function automatic bit popExp(input int k, output logic [31:0] w);
        w = '0;
        if (qSize(k) == 0) return 1'b0;
        case (k)
            0:       w = expQ0.pop_front();
            1:       w = expQ1.pop_front();
            default: w = expQ2.pop_front();
        endcase
        return 1'b1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cycleCnt);
        end
    endtask

    // Drives one put on instance k at a negedge; the word is expected on the line only if the
    // bench's own occupancy reasoning says RDY is high for this attempt.
    task automatic applyStimulus(input int k, input logic [31:0] w, input bit expRdy);
        @(negedge clk);
        case (k)
            0:       begin en0 = 1'b1; data0 = w; end
            1:       begin en1 = 1'b1; data1 = w; end
            default: begin en2 = 1'b1; data2 = w; end
        endcase
        checkOutput($sformatf("rdy at put inst%0d", k), 32'(rdyOf(k)), 32'(expRdy));
        @(posedge clk);
        if (expRdy) begin
            case (k)
                0:       expQ0.push_back(w);
                1:       expQ1.push_back(w);
                default: expQ2.push_back(w);
            endcase
        end
        #1;
        lastPutCycle = cycleCnt;
        en0 = 1'b0;
        en1 = 1'b0;
        en2 = 1'b0;
    endtask

    task automatic waitUntil(input int target);
        do @(negedge clk); while (cycleCnt < target);
    endtask

    task automatic waitRdy(input int k);
        int n;
        n = 0;
        while (rdyOf(k) !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("rdy wait bound", 32'(n < 2000), 32'd1);
    endtask

    task automatic waitDrain(input int k, input int budget);
        int n;
        n = 0;
        while ((qSize(k) != 0 || busyOf(k) !== 1'b0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput($sformatf("drain bound inst%0d", k), 32'(n < budget), 32'd1);
    endtask

    // Reference UART receiver: every cycle of every bit slot is sampled, so bit width,
    // start/stop levels and inter-byte gaps are all checked; a reset abandons the frame.
    task automatic monitorLine(input int k);
        int          b, s, nSlots, byteIdx, gap;
        logic [31:0] acc, expW;
        logic [7:0]  dataByte;
        logic        v, first;
        bit          bad, aborted;
        b = baudOf(k);
        s = stopsOf(k);
        nSlots = 9 + s;
        byteIdx = 0;
        acc = '0;
        first = 1'b1;
        forever begin
            gap = 0;
            @(negedge clk);
            while (lineOf(k) !== 1'b0 || rstN !== 1'b1) begin
                if (rstN !== 1'b1) byteIdx = 0;
                gap++;
                @(negedge clk);
            end
            bad = 1'b0;
            aborted = 1'b0;
            dataByte = '0;
            for (int slot = 0; slot < nSlots && !aborted; slot++) begin
                for (int c = 0; c < b && !aborted; c++) begin
                    if (slot != 0 || c != 0) @(negedge clk);
                    if (rstN !== 1'b1) begin
                        aborted = 1'b1;
                    end else begin
                        v = lineOf(k);
                        if (c == 0) first = v;
                        else if (v !== first) bad = 1'b1;
                        if (slot == 0 && v !== 1'b0) bad = 1'b1;
                        if (slot >= 9 && v !== 1'b1) bad = 1'b1;
                        if (slot >= 1 && slot <= 8 && c == 0) dataByte[slot-1] = v;
                    end
                end
            end
            if (aborted) begin
                byteIdx = 0;
            end else begin
                checkOutput($sformatf("framing inst%0d byte%0d", k, byteIdx), {31'b0, bad}, 32'd0);
                if (byteIdx != 0) checkOutput($sformatf("intra-word gap inst%0d", k), 32'(gap), 32'd0);
                else lastWordGap[k] = gap;
                acc[byteIdx*8 +: 8] = dataByte;
                byteIdx++;
                if (byteIdx == 4) begin
                    byteIdx = 0;
                    wordsSeen[k]++;
                    if (popExp(k, expW)) begin
                        checkOutput($sformatf("word inst%0d", k), acc, expW);
                    end else begin
                        nCompared++;
                        nMismatch++;
                        $display("[TB] FAIL unexpected word inst%0d: got 0x%08h, expected none", k, acc);
                    end
                end
            end
        end
    endtask

    initial monitorLine(0);
    initial monitorLine(1);
    initial monitorLine(2);

    initial begin
        #3_000_000;
        nMismatch++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

    initial begin
        logic [31:0] words [6];
        int          c, c1, seen, zeros, pick, gapLen;
        for (int k = 0; k < 3; k++) begin
            lastWordGap[k] = -1;
            wordsSeen[k] = 0;
        end

        // Reset state and two-flop release timing.
        repeat (3) @(negedge clk);
        checkOutput("reset line", 32'(line0), 32'd1);
        checkOutput("reset rdy", 32'(rdy0), 32'd0);
        checkOutput("reset busy", 32'(busy0), 32'd0);
        checkOutput("reset line inst1", 32'(line1), 32'd1);
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("rdy 1 edge after release", 32'(rdy0), 32'd0);
        @(negedge clk);
        checkOutput("rdy 2 edges after release", 32'(rdy0), 32'd1);

        // Single word: start bit two cycles after the put edge, 160-cycle frame.
        $display("[TB] single word");
        applyStimulus(0, 32'h44332211, 1'b1);
        c = lastPutCycle;
        checkOutput("busy after put", 32'(busy0), 32'd1);
        waitUntil(c + 1);
        checkOutput("line idle before start", 32'(line0), 32'd1);
        waitUntil(c + 2);
        checkOutput("first start bit", 32'(line0), 32'd0);
        waitUntil(c + 160);
        checkOutput("busy at frame end", 32'(busy0), 32'd1);
        waitUntil(c + 161);
        checkOutput("busy after frame", 32'(busy0), 32'd0);
        waitDrain(0, 400);

        // Back-to-back words must run with no idle gap.
        $display("[TB] back-to-back");
        applyStimulus(0, 32'hA5A5A5A5, 1'b1);
        applyStimulus(0, 32'h0000FFFF, 1'b1);
        waitDrain(0, 600);
        checkOutput("word-to-word gap", 32'(lastWordGap[0]), 32'd0);

        // Backpressure: 1 in the serializer + 4 buffered, the 6th attempt is dropped.
        $display("[TB] backpressure");
        for (int i = 0; i < 6; i++) begin
            words[i] = $urandom;
            applyStimulus(0, words[i], i < 5);
            if (i == 0) c1 = lastPutCycle;
        end
        waitUntil(c1 + 160);
        checkOutput("rdy while full", 32'(rdy0), 32'd0);
        waitUntil(c1 + 161);
        checkOutput("rdy after dequeue", 32'(rdy0), 32'd1);
        waitDrain(0, 1500);

        // Asynchronous reset in the middle of byte 2's data bits.
        $display("[TB] async reset");
        applyStimulus(0, 32'h5A00C3E1, 1'b1);
        c = lastPutCycle;
        waitUntil(c + 96);
        checkOutput("byte2 data bit", 32'(line0), 32'd0);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("line on async reset", 32'(line0), 32'd1);
        checkOutput("rdy on async reset", 32'(rdy0), 32'd0);
        checkOutput("busy on async reset", 32'(busy0), 32'd0);
        expQ0.delete();
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("rdy 1 edge after re-release", 32'(rdy0), 32'd0);
        @(negedge clk);
        checkOutput("rdy 2 edges after re-release", 32'(rdy0), 32'd1);
        seen = wordsSeen[0];
        zeros = 0;
        repeat (200) begin
            @(negedge clk);
            if (line0 !== 1'b1) zeros++;
        end
        checkOutput("residual low samples", 32'(zeros), 32'd0);
        checkOutput("residual words", 32'(wordsSeen[0]), 32'(seen));
        checkOutput("busy after reset", 32'(busy0), 32'd0);

        // Randomized traffic with bursts and idle stretches.
        $display("[TB] random traffic");
        for (int i = 0; i < 12; i++) begin
            pick = $urandom_range(0, 3);
            gapLen = (pick == 1) ? $urandom_range(1, 20) : (pick == 2) ? $urandom_range(20, 200) : 0;
            repeat (gapLen) @(negedge clk);
            waitRdy(0);
            applyStimulus(0, $urandom, 1'b1);
        end
        waitDrain(0, 5000);

        // Two stop bits: 44-cycle bytes, 176-cycle word.
        $display("[TB] two stop bits");
        applyStimulus(1, 32'h000000FF, 1'b1);
        c = lastPutCycle;
        waitUntil(c + 2);
        checkOutput("start bit inst1", 32'(line1), 32'd0);
        waitUntil(c + 176);
        checkOutput("busy at frame end inst1", 32'(busy1), 32'd1);
        waitUntil(c + 177);
        checkOutput("busy after frame inst1", 32'(busy1), 32'd0);
        waitDrain(1, 400);

        // Minimum divider: 2-cycle bits, 80-cycle word.
        $display("[TB] baud divider 2");
        applyStimulus(2, 32'h80000001, 1'b1);
        c = lastPutCycle;
        waitUntil(c + 2);
        checkOutput("start bit inst2", 32'(line2), 32'd0);
        waitUntil(c + 80);
        checkOutput("busy at frame end inst2", 32'(busy2), 32'd1);
        waitUntil(c + 81);
        checkOutput("busy after frame inst2", 32'(busy2), 32'd0);
        waitDrain(2, 300);

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
